// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV32E subset core (OP-IMM, LOAD, STORE, JALR, LUI) sharing one ALU.
// Instruction and data memories are reached through req/ready handshakes.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] pc_dbg
);

  if (XLEN != 32) begin : gen_bad_xlen
    $error("XLEN must be 32");
  end
  if (NREGS != 32 && NREGS != 16) begin : gen_bad_nregs
    $error("NREGS must be 16 or 32");
  end

  localparam int unsigned RegAw = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_store, is_load, is_jalr;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign is_store = (opcode == OpStore);
  assign is_load  = (opcode == OpLoad);
  assign is_jalr  = (opcode == OpJalr);

  // Decode: legality and immediate formation.
  logic            illegal, uses_rd, uses_rs1, uses_rs2;
  logic [XLEN-1:0] imm;

  always_comb begin
    illegal  = 1'b0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    imm      = {{20{ir_q[31]}}, ir_q[31:20]};
    unique case (opcode)
      OpImm: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != {1'b0, ir_q[30], 5'b00000}) illegal = 1'b1;
      end
      OpLoad: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      OpStore: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        if (funct3 >= 3'b011) illegal = 1'b1;
      end
      OpJalr: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OpLui: begin
        uses_rd = 1'b1;
        imm     = {ir_q[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (NREGS == 16 &&
        ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]))) begin
      illegal = 1'b1;
    end
  end

  // Shared ALU, used in EXEC.
  logic [XLEN-1:0] sum, alu_res;
  logic [4:0]      shamt;
  logic            misaligned;

  assign sum   = a_q + imm_q;
  assign shamt = imm_q[4:0];

  always_comb begin
    alu_res = sum;
    unique case (opcode)
      OpImm: begin
        unique case (funct3)
          3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(imm_q)};
          3'b011:  alu_res = {31'b0, a_q < imm_q};
          3'b100:  alu_res = a_q ^ imm_q;
          3'b110:  alu_res = a_q | imm_q;
          3'b111:  alu_res = a_q & imm_q;
          3'b001:  alu_res = a_q << shamt;
          3'b101:  alu_res = ir_q[30] ? $unsigned($signed(a_q) >>> shamt) : a_q >> shamt;
          default: alu_res = sum;
        endcase
      end
      OpLui:   alu_res = imm_q;
      OpJalr:  alu_res = {sum[31:1], 1'b0};
      default: alu_res = sum;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      if (funct3[1:0] == 2'b01 && sum[0]) misaligned = 1'b1;
      if (funct3[1:0] == 2'b10 && sum[1:0] != 2'b00) misaligned = 1'b1;
    end
    if (is_jalr && sum[1]) misaligned = 1'b1;
  end

  // Load lane extraction and store lane placement.
  logic [XLEN-1:0] lane, load_val, wb_data;
  logic [3:0]      store_be;

  assign lane = dmem_rdata >> {alu_q[1:0], 3'b000};

  always_comb begin
    unique case (funct3[1:0])
      2'b00:   load_val = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_val = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    unique case (funct3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << alu_q[1:0];
        dmem_wdata = {4{b_q[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << {alu_q[1], 1'b0};
        dmem_wdata = {2{b_q[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        dmem_wdata = b_q;
      end
    endcase
  end

  assign wb_data = is_jalr ? pc_q + 32'd4 : (is_load ? mdr_q : alu_q);

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_ready) state_d = StDecode;
      StDecode: state_d = illegal ? StHalt : StExec;
      StExec: begin
        if (misaligned)               state_d = StHalt;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StWb;
      end
      StMem:    if (dmem_ready) state_d = is_store ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: if (imem_ready) ir_q <= imem_rdata;
        StDecode: begin
          a_q   <= rf_q[rs1[RegAw-1:0]];
          b_q   <= rf_q[rs2[RegAw-1:0]];
          imm_q <= imm;
        end
        StExec: alu_q <= alu_res;
        StMem: begin
          if (dmem_ready) begin
            if (is_store) pc_q <= pc_q + 32'd4;
            else          mdr_q <= load_val;
          end
        end
        StWb: begin
          if (rd != 5'd0) rf_q[rd[RegAw-1:0]] <= wb_data;
          pc_q <= is_jalr ? alu_q : pc_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // Requests are gated by reset so an outstanding transfer is dropped at once.
  assign imem_req  = (state_q == StFetch) && !reset;
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == StMem) && !reset;
  assign dmem_we   = dmem_req && is_store;
  assign dmem_be   = dmem_we ? store_be : 4'b0000;
  assign dmem_addr = {alu_q[XLEN-1:2], 2'b00};
  assign retire    = !reset &&
                     ((state_q == StWb) || (state_q == StMem && is_store && dmem_ready));
  assign halted    = (state_q == StHalt);
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Scoreboard bench for rv_multicycle_core: expected retires/stores are queued by the
// stimulus and checked by a negedge monitor; memories have configurable wait states.
module tb_rv_multicycle_core;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [6:0]  OpI = 7'b0010011, OpL = 7'b0000011, OpJ = 7'b1100111, OpU = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_dbg;
  logic [3:0]  dmem_be;

  logic        imem_req16, dmem_req16, dmem_we16, retire16, halted16;
  logic [31:0] imem_addr16, dmem_addr16, dmem_wdata16, pc_dbg16;
  logic [3:0]  dmem_be16;

  rv_multicycle_core #(.RESET_PC(RstPc), .NREGS(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
  );

  // RV32E instance always fetches ADDI x17,x0,1 and must halt on it.
  rv_multicycle_core #(.RESET_PC(RstPc), .NREGS(16), .XLEN(32)) dut16 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ready(1'b1),
    .imem_rdata(32'h0010_0893),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_be(dmem_be16), .dmem_addr(dmem_addr16),
    .dmem_wdata(dmem_wdata16), .dmem_ready(1'b0), .dmem_rdata(32'h0),
    .retire(retire16), .halted(halted16), .pc_dbg(pc_dbg16)
  );

  // Memory models with per-transfer wait states.
  logic [31:0] imem [256];
  logic [31:0] dword, dinit;
  int          icfg = 0, dcfg = 0, il, dl, cyc;

  assign imem_ready = imem_req && (il == 0);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ready = dmem_req && (dl == 0);
  assign dmem_rdata = dword;

  always @(posedge clk) begin
    if (reset) begin
      il <= icfg; dl <= dcfg; cyc <= 0; dword <= dinit;
    end else begin
      cyc <= cyc + 1;
      if (imem_req) il <= imem_ready ? icfg : il - 1;
      if (dmem_req) dl <= dmem_ready ? dcfg : dl - 1;
      if (dmem_req && dmem_ready && dmem_we)
        for (int b = 0; b < 4; b++) if (dmem_be[b]) dword[8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard.
  typedef struct {
    logic [31:0] pc; int gap; bit st; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
  } exp_t;
  exp_t q[$];

  task automatic exp_ret(input logic [31:0] pc, input int gap);
    exp_t e; e.pc = pc; e.gap = gap; e.st = 1'b0; e.addr = '0; e.be = '0; e.wdata = '0;
    q.push_back(e);
  endtask

  task automatic exp_st(input logic [31:0] pc, input int gap, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
    exp_t e; e.pc = pc; e.gap = gap; e.st = 1'b1; e.addr = addr; e.be = be; e.wdata = wdata;
    q.push_back(e);
  endtask

  // Monitor: retire events and request stability while stalled.
  int          last_ret;
  logic        pi_req, pi_hs, pd_req, pd_hs;
  logic [31:0] pi_addr, pd_addr, pd_wdata;
  exp_t        m;

  always @(negedge clk) begin
    if (reset) begin
      last_ret = -1; pi_req = 1'b0; pd_req = 1'b0;
    end else begin
      if (retire16) begin
        checks++; errors++;
        $display("FAIL rv32e_retire actual=1 expected=0");
      end
      if (retire) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire actual_pc=%h expected=none", pc_dbg);
        end else begin
          m = q.pop_front();
          chk("retire_pc", pc_dbg, m.pc);
          chk("retire_gap", cyc - last_ret, m.gap);
          if (m.st) begin
            chk("store_we", {31'b0, dmem_req && dmem_we}, 32'd1);
            chk("store_addr", dmem_addr, m.addr);
            chk("store_be", {28'b0, dmem_be}, {28'b0, m.be});
            chk("store_wdata", dmem_wdata, m.wdata);
          end
        end
        last_ret = cyc;
      end
      if (pi_req && !pi_hs) begin
        chk("imem_req_hold", {31'b0, imem_req}, 32'd1);
        chk("imem_addr_hold", imem_addr, pi_addr);
      end
      if (pd_req && !pd_hs) begin
        chk("dmem_req_hold", {31'b0, dmem_req}, 32'd1);
        chk("dmem_addr_hold", dmem_addr, pd_addr);
        chk("dmem_wdata_hold", dmem_wdata, pd_wdata);
      end
      pi_req = imem_req; pi_hs = imem_req && imem_ready; pi_addr = imem_addr;
      pd_req = dmem_req; pd_hs = dmem_req && dmem_ready; pd_addr = dmem_addr;
      pd_wdata = dmem_wdata;
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0033;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RstPc);
    chk("rst_pc_dbg", pc_dbg, RstPc);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_retire_halted", {30'b0, retire, halted}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit want_halt);
    int n = 0;
    while ((q.size() != 0 || (want_halt && !halted)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("wait_budget", {31'b0, n >= budget}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dinit = 32'h0;
    // Run A: OP-IMM sequence then an illegal opcode; RV32E instance halts on x17.
    fill_imem();
    imem[0] = enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, OpI);
    imem[1] = enc_i(12'h001, 5'd1, 3'b011, 5'd2, OpI);
    imem[2] = enc_i(12'h401, 5'd1, 3'b101, 5'd3, OpI);
    exp_ret(32'h00, 4); exp_ret(32'h04, 4); exp_ret(32'h08, 4);
    apply_reset();
    chk("rst_x1_zero", dut.rf_q[1], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rv32e_halted", {31'b0, halted16}, 32'd1);
    chk("rv32e_imem_req", {31'b0, imem_req16}, 32'd0);
    wait_done(100, 1'b1);
    chk("a_x1", dut.rf_q[1], 32'hFFFF_FFFB);
    chk("a_x2", dut.rf_q[2], 32'h0000_0000);
    chk("a_x3", dut.rf_q[3], 32'hFFFF_FFFD);
    repeat (3) @(negedge clk);
    chk("a_pc_frozen", pc_dbg, RstPc + 32'd12);
    chk("a_halt_reqs", {30'b0, imem_req, dmem_req}, 32'd0);

    // Run B: loads, stores, LUI, JALR and a misaligned JALR.
    fill_imem();
    dinit = 32'h80FF_7F01;
    imem[0]   = enc_i(12'h100, 5'd0, 3'b000, 5'd4, OpI);
    imem[1]   = enc_i(12'h003, 5'd4, 3'b000, 5'd6, OpL);
    imem[2]   = enc_i(12'h001, 5'd4, 3'b100, 5'd7, OpL);
    imem[3]   = enc_i(12'h002, 5'd4, 3'b001, 5'd8, OpL);
    imem[4]   = enc_i(12'h002, 5'd4, 3'b101, 5'd9, OpL);
    imem[5]   = {20'h12345, 5'd5, OpU};
    imem[6]   = enc_i(12'h678, 5'd5, 3'b000, 5'd5, OpI);
    imem[7]   = enc_s(12'h003, 5'd5, 5'd4, 3'b000);
    imem[8]   = enc_s(12'h002, 5'd5, 5'd4, 3'b001);
    imem[9]   = enc_s(12'h000, 5'd5, 5'd4, 3'b010);
    imem[10]  = enc_i(12'h201, 5'd0, 3'b000, 5'd2, OpI);
    imem[11]  = enc_i(12'h000, 5'd2, 3'b000, 5'd1, OpJ);
    imem[128] = enc_i(12'h202, 5'd0, 3'b000, 5'd2, OpI);
    imem[129] = enc_i(12'h000, 5'd2, 3'b000, 5'd11, OpJ);
    exp_ret(32'h00, 4); exp_ret(32'h04, 5); exp_ret(32'h08, 5); exp_ret(32'h0C, 5);
    exp_ret(32'h10, 5); exp_ret(32'h14, 4); exp_ret(32'h18, 4);
    exp_st(32'h1C, 4, 32'h100, 4'b1000, 32'h7878_7878);
    exp_st(32'h20, 4, 32'h100, 4'b1100, 32'h5678_5678);
    exp_st(32'h24, 4, 32'h100, 4'b1111, 32'h1234_5678);
    exp_ret(32'h28, 4); exp_ret(32'h2C, 4); exp_ret(32'h200, 4);
    apply_reset();
    chk("rst_x3_cleared", dut.rf_q[3], 32'd0);
    wait_done(300, 1'b1);
    chk("b_lb", dut.rf_q[6], 32'hFFFF_FF80);
    chk("b_lbu", dut.rf_q[7], 32'h0000_007F);
    chk("b_lh", dut.rf_q[8], 32'hFFFF_80FF);
    chk("b_lhu", dut.rf_q[9], 32'h0000_80FF);
    chk("b_x5", dut.rf_q[5], 32'h1234_5678);
    chk("b_jalr_link", dut.rf_q[1], 32'h0000_0030);
    chk("b_x11_unchanged", dut.rf_q[11], 32'd0);
    chk("b_dmem_word", dword, 32'h1234_5678);
    chk("b_pc_frozen", pc_dbg, 32'h0000_0204);
    chk("b_halted", {31'b0, halted}, 32'd1);

    // Run C: wait-state LW, then reset in the middle of a second LW's MEM step.
    fill_imem();
    dinit = 32'hCAFE_F00D;
    icfg = 3;
    dcfg = 2;
    imem[0] = enc_i(12'h100, 5'd0, 3'b010, 5'd12, OpL);
    imem[1] = enc_i(12'h100, 5'd0, 3'b010, 5'd13, OpL);
    exp_ret(32'h00, 10);
    apply_reset();
    chk("rst_x5_cleared", dut.rf_q[5], 32'd0);
    wait_done(100, 1'b0);
    chk("c_lw", dut.rf_q[12], 32'hCAFE_F00D);
    begin
      int n = 0;
      while (!dmem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("c_reach_mem", {31'b0, dmem_req}, 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("c_rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("c_rst_pc", pc_dbg, RstPc);
    chk("c_rst_x12", dut.rf_q[12], 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("c_queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle I-type datapath. Executes the RV32I subset OP-IMM, LOAD, STORE, JALR and LUI.
- A sequential FSM shares one ALU across FETCH/DECODE/EXEC/MEM/WB steps.
- Instruction and data memories sit outside the block and are reached through req/ready handshakes, so wait-state memories are supported.
- Sits at the top of the CPU hierarchy. An illegal instruction or misaligned access halts the core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, register count: 32 (RV32I) or 16 (RV32E); any other value is a synthesis error.
- XLEN, 32, datapath width; only 32 is legal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= PC)
- imem_ready  in  1  fetch completes on an edge where imem_req && imem_ready
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- dmem_req  out  1  data request
- dmem_we  out  1  1=store, 0=load
- dmem_be  out  4  byte enables for stores; 4'b0000 for loads
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  XLEN  store data, shifted to the byte lane
- dmem_ready  in  1  data transfer completes on an edge where dmem_req && dmem_ready
- dmem_rdata  in  XLEN  load word, valid when dmem_ready=1
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction
- halted  out  1  high from entry to HALT until reset
- pc_dbg  out  XLEN  current PC

Behaviour:
Reset (async, any state):
- PC=RESET_PC, state=FETCH.
- All registers x0..x(NREGS-1) = 0.
- All outputs 0 except imem_addr=pc_dbg=RESET_PC.
- imem_req rises in the first cycle after reset deasserts.

FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1, imem_addr=PC.
  - Hold req and address stable until imem_ready.
  - On the handshake edge, latch IR=imem_rdata and go to DECODE.
- DECODE: read rs1/rs2 into A/B and form the immediate (I, S or U). Illegal if any of:
  - opcode not in {0010011, 0000011, 0100011, 1100111, 0110111}
  - bad funct3 (LOAD 011/110/111; STORE >=011; JALR !=000)
  - SLLI/SRLI with funct7!=0000000, or SRAI with funct7!=0100000
  - NREGS=16 and any used register index has bit4=1
  - Illegal goes to HALT; otherwise go to EXEC.
- EXEC: ALU computes A op imm, result latched into ALUOut.
  - OP-IMM: ADD/SLT(signed)/SLTU/XOR/OR/AND; shamt=imm[4:0], SRA arithmetic.
  - LOAD/STORE: address = rs1+imm.
  - JALR: target = (rs1+imm)&~1, link=PC+4.
  - LUI: result = imm[31:12]<<12.
  - Misaligned access goes to HALT: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, JALR with target[1]=1.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: dmem_req=1 until the dmem_ready edge.
  - Store: dmem_we=1; be = 0001<<a[1:0] (SB), 0011<<a[1] *2 (SH), 1111 (SW); wdata = rs2 replicated into the lanes. On the handshake: retire=1, PC+=4, go to FETCH.
  - Load: latch the lane of rdata selected by a[1:0], sign- or zero-extended by funct3[2], then go to WB.
- WB: write rd (ALU result, load data, or PC+4 for JALR); writes to x0 are discarded.
  - retire=1.
  - PC = JALR target or PC+4.
  - Go to FETCH.
- HALT: all requests 0, halted=1, PC frozen; only reset exits.

Latency with zero-wait memory:
- OP-IMM/LUI/JALR: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Each ready-low cycle adds one cycle.

Edge cases:
- rs1 = rd: the source is read in DECODE, before the write.
- ready asserted while req=0 is ignored.
- PC wraps modulo 2^32.
- Reset asserted during an outstanding req drops req immediately; the transaction is abandoned.

Test Plan:
1. ADDI x1,x0,-5; SLTIU x2,x1,1; SRAI x3,x1,1 with zero-wait memory -> x1=FFFFFFFB, x2=0, x3=FFFFFFFD; retire every 4 cycles; PC=RESET_PC+12.
2. rdata=0x80FF7F01 at 0x100: LB off 3 -> FFFFFF80; LBU off 1 -> 0x7F; LH off 2 -> FFFF80FF; LHU off 2 -> 0x80FF; each retires in 5 cycles.
3. SB x5 (=0x12345678) to 0x103 -> be=1000, wdata lane3=0x78; SH to 0x102 -> be=1100, wdata=0x56785678.
4. JALR x1,0(x2) with x2=0x201 -> x1=PC+4, next fetch at 0x200; with x2=0x202 -> halted=1, x1 unchanged, no retire.
5. Illegal opcode 0x00000033, or NREGS=16 with ADDI x17 -> halted within 2 cycles of the fetch handshake, imem_req=0 thereafter.
6. imem_ready held low for 3 cycles, then dmem_ready low for 2 cycles on a LW -> req and address stable throughout, retire at cycle 10; reset mid-MEM -> PC=RESET_PC, registers 0, dmem_req=0 immediately.
